// File: rtl/cv32e40p_register_file_mp.sv
// Multi-port integer register file with a per-register pending scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to the read ports.
module cv32e40p_register_file_mp #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_RD     = 3,
    parameter int NUM_WR     = 2,
    parameter int ZERO_REG   = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] raddr_i,
    output logic [NUM_RD*DATA_WIDTH-1:0] rdata_o,
    output logic [NUM_RD-1:0]            busy_o,
    input  logic [NUM_WR*ADDR_WIDTH-1:0] waddr_i,
    input  logic [NUM_WR*DATA_WIDTH-1:0] wdata_i,
    input  logic [NUM_WR-1:0]            we_i,
    input  logic                         rsv_i,
    input  logic [ADDR_WIDTH-1:0]        rsv_addr_i,
    output logic [ADDR_WIDTH:0]          pend_cnt_o
);

    localparam int NUM_WORDS = 2 ** ADDR_WIDTH;
    localparam int CNT_W     = ADDR_WIDTH + 1;
    localparam bit ZERO_EN   = (ZERO_REG != 0);

    // No handshake: every write and reserve presented in a cycle is accepted
    // on the next rising edge; reads are always valid.

    logic [DATA_WIDTH-1:0] mem    [NUM_WORDS];
    logic [NUM_WORDS-1:0]  pend;
    logic [CNT_W-1:0]      pend_cnt;

    logic [NUM_WORDS-1:0]  wr_en;
    logic [DATA_WIDTH-1:0] wr_val [NUM_WORDS];
    logic [NUM_WORDS-1:0]  rsv_vec;
    logic [NUM_WORDS-1:0]  pend_next;
    logic [CNT_W-1:0]      clr_cnt;
    logic                  set_inc;
    logic [CNT_W-1:0]      cnt_next;

    // Per-word write decode; later ports overwrite earlier ones so the
    // highest-index port wins an address collision.
    always_comb begin
        for (int w = 0; w < NUM_WORDS; w++) begin
            wr_en[w]  = 1'b0;
            wr_val[w] = '0;
        end
        for (int p = 0; p < NUM_WR; p++) begin
            if (we_i[p]) begin
                wr_en[waddr_i[p*ADDR_WIDTH +: ADDR_WIDTH]]  = 1'b1;
                wr_val[waddr_i[p*ADDR_WIDTH +: ADDR_WIDTH]] = wdata_i[p*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        if (ZERO_EN) begin
            wr_en[0] = 1'b0;
        end
    end

    always_comb begin
        rsv_vec = '0;
        if (rsv_i) begin
            rsv_vec[rsv_addr_i] = 1'b1;
        end
        if (ZERO_EN) begin
            rsv_vec[0] = 1'b0;
        end
    end

    // A reserve beats a same-cycle write: the register takes the data but
    // stays pending for the new producer.
    always_comb begin
        pend_next = rsv_vec | (pend & ~wr_en);
        set_inc   = |(rsv_vec & ~pend);
        clr_cnt   = '0;
        for (int w = 0; w < NUM_WORDS; w++) begin
            if (pend[w] && wr_en[w] && !rsv_vec[w]) begin
                clr_cnt = clr_cnt + CNT_W'(1);
            end
        end
        cnt_next = pend_cnt + CNT_W'(set_inc) - clr_cnt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int w = 0; w < NUM_WORDS; w++) begin
                mem[w] <= '0;
            end
            pend     <= '0;
            pend_cnt <= '0;
        end else begin
            for (int w = 0; w < NUM_WORDS; w++) begin
                if (wr_en[w]) begin
                    mem[w] <= wr_val[w];
                end
            end
            pend     <= pend_next;
            pend_cnt <= cnt_next;
        end
    end

    assign pend_cnt_o = pend_cnt;

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_WIDTH-1:0] ra;
        logic [DATA_WIDTH-1:0] rd;
        logic                  rb;

        assign ra = raddr_i[k*ADDR_WIDTH +: ADDR_WIDTH];

        always_comb begin
            rd = mem[ra];
            rb = pend[ra];
`ifdef REGFILE_BYPASS_EN
            // Forward the winning write; a same-cycle reserve keeps it busy.
            if (wr_en[ra]) begin
                rd = wr_val[ra];
                rb = rsv_vec[ra];
            end
`endif
            if (ZERO_EN && (ra == '0)) begin
                rd = '0;
                rb = 1'b0;
            end
        end

        assign rdata_o[k*DATA_WIDTH +: DATA_WIDTH] = rd;
        assign busy_o[k]                           = rb;
    end

endmodule

// File: tb/tb_cv32e40p_register_file_mp.sv
// Directed bench for cv32e40p_register_file_mp (default 32x32, 3R/2W, x0 hardwired).
// Same-cycle expectations follow REGFILE_BYPASS_EN when it is defined.
module tb_cv32e40p_register_file_mp;

    logic        clk;
    logic        rst;
    logic [14:0] raddr;
    logic [95:0] rdata;
    logic [2:0]  busy;
    logic [9:0]  waddr;
    logic [63:0] wdata;
    logic [1:0]  we;
    logic        rsv;
    logic [4:0]  rsv_addr;
    logic [5:0]  pend_cnt;

    int checks;
    int errors;

    cv32e40p_register_file_mp dut (
        .clk        (clk),
        .rst        (rst),
        .raddr_i    (raddr),
        .rdata_o    (rdata),
        .busy_o     (busy),
        .waddr_i    (waddr),
        .wdata_i    (wdata),
        .we_i       (we),
        .rsv_i      (rsv),
        .rsv_addr_i (rsv_addr),
        .pend_cnt_o (pend_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic set_rd(input int k, input logic [4:0] a);
        raddr[k*5 +: 5] = a;
    endtask

    task automatic wr(input int p, input logic [4:0] a, input logic [31:0] d);
        we[p]            = 1'b1;
        waddr[p*5 +: 5]  = a;
        wdata[p*32 +: 32] = d;
    endtask

    task automatic idle();
        we       = '0;
        waddr    = '0;
        wdata    = '0;
        rsv      = 1'b0;
        rsv_addr = '0;
    endtask

    // Advance past the next rising edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rd(input int k);
        return rdata[k*32 +: 32];
    endfunction

    task automatic check_all_zero(input string tag);
        for (int a = 0; a < 32; a++) begin
            for (int k = 0; k < 3; k++) set_rd(k, 5'(a));
            #1;
            for (int k = 0; k < 3; k++) begin
                check($sformatf("%s_rdata_a%0d_p%0d", tag, a, k), rd(k), 32'h0);
                check($sformatf("%s_busy_a%0d_p%0d", tag, a, k), {31'b0, busy[k]}, 32'h0);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        raddr  = '0;
        idle();
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check("rst_cnt", {26'b0, pend_cnt}, 32'd0);
        check_all_zero("rst");

        // Write collision on x5: port1 wins; same-cycle read sees old value
        wr(0, 5'd5, 32'hDEADBEEF);
        wr(1, 5'd5, 32'h12345678);
        set_rd(0, 5'd5);
        #1;
`ifdef REGFILE_BYPASS_EN
        check("coll_same_cycle", rd(0), 32'h12345678);
`else
        check("coll_same_cycle", rd(0), 32'h0);
`endif
        tick();
        idle();
        #1;
        check("coll_x5", rd(0), 32'h12345678);
        check("coll_cnt", {26'b0, pend_cnt}, 32'd0);

        // Reserve x7, x8, x7 again
        rsv = 1'b1; rsv_addr = 5'd7;
        tick();
        check("rsv7_cnt", {26'b0, pend_cnt}, 32'd1);
        rsv_addr = 5'd8;
        tick();
        check("rsv8_cnt", {26'b0, pend_cnt}, 32'd2);
        rsv_addr = 5'd7;
        tick();
        idle();
        set_rd(0, 5'd7);
        set_rd(1, 5'd8);
        #1;
        check("rsv7again_cnt", {26'b0, pend_cnt}, 32'd2);
        check("busy_x7", {31'b0, busy[0]}, 32'd1);
        check("busy_x8", {31'b0, busy[1]}, 32'd1);

        // Port1 writes x7 -> clears its pending bit
        wr(1, 5'd7, 32'hA5);
        tick();
        idle();
        #1;
        check("w7_busy", {31'b0, busy[0]}, 32'd0);
        check("w7_busy_x8", {31'b0, busy[1]}, 32'd1);
        check("w7_cnt", {26'b0, pend_cnt}, 32'd1);
        check("w7_rdata", rd(0), 32'hA5);

        // Reserve and write x9 in one cycle -> written, still pending
        rsv = 1'b1; rsv_addr = 5'd9;
        wr(0, 5'd9, 32'h55);
        tick();
        idle();
        set_rd(2, 5'd9);
        #1;
        check("rw9_rdata", rd(2), 32'h55);
        check("rw9_busy", {31'b0, busy[2]}, 32'd1);
        check("rw9_cnt", {26'b0, pend_cnt}, 32'd2);

        // Write and reserve x0 -> ignored
        rsv = 1'b1; rsv_addr = 5'd0;
        wr(0, 5'd0, 32'hFF);
        tick();
        idle();
        set_rd(0, 5'd0);
        #1;
        check("x0_rdata", rd(0), 32'h0);
        check("x0_busy", {31'b0, busy[0]}, 32'd0);
        check("x0_cnt", {26'b0, pend_cnt}, 32'd2);

        // Two distinct pending registers cleared in one cycle
        wr(0, 5'd8, 32'h88);
        wr(1, 5'd9, 32'h99);
        tick();
        idle();
        set_rd(0, 5'd8);
        set_rd(1, 5'd9);
        #1;
        check("clr2_cnt", {26'b0, pend_cnt}, 32'd0);
        check("clr2_x8", rd(0), 32'h88);
        check("clr2_x9", rd(1), 32'h99);
        check("clr2_busy", {29'b0, busy}, 32'd0);

        // Both ports hit the same pending register: one decrement only
        rsv = 1'b1; rsv_addr = 5'd10;
        tick();
        idle();
        check("rsv10_cnt", {26'b0, pend_cnt}, 32'd1);
        wr(0, 5'd10, 32'h111);
        wr(1, 5'd10, 32'h222);
        tick();
        idle();
        set_rd(0, 5'd10);
        #1;
        check("dup_clr_cnt", {26'b0, pend_cnt}, 32'd0);
        check("dup_clr_rdata", rd(0), 32'h222);

        // Same-cycle read of a register being written
        wr(0, 5'd3, 32'hCAFE);
        set_rd(2, 5'd3);
        #1;
`ifdef REGFILE_BYPASS_EN
        check("byp_rdata", rd(2), 32'hCAFE);
`else
        check("byp_rdata", rd(2), 32'h0);
`endif
        check("byp_busy", {31'b0, busy[2]}, 32'd0);
        tick();
        idle();
        #1;
        check("w3_rdata", rd(2), 32'hCAFE);

        // Fill the scoreboard x1..x31
        for (int a = 1; a < 32; a++) begin
            rsv = 1'b1; rsv_addr = 5'(a);
            tick();
        end
        rsv_addr = 5'd0;
        tick();
        idle();
        set_rd(0, 5'd1);
        set_rd(1, 5'd31);
        set_rd(2, 5'd0);
        #1;
        check("fill_cnt", {26'b0, pend_cnt}, 32'd31);
        check("fill_busy", {29'b0, busy}, 32'b011);

        // Reset with a write and reserve in flight
        rst = 1'b1;
        wr(1, 5'd4, 32'h1234);
        rsv = 1'b1; rsv_addr = 5'd4;
        tick();
        rst = 1'b0;
        idle();
        #1;
        check("rst2_cnt", {26'b0, pend_cnt}, 32'd0);
        check_all_zero("rst2");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
